rou_target: RTL and testbench
=============================

Name: rou_target

Overview:
- Terminal responder for the rou bus: the far end of the flits that initiators and the rou power-crossing bridges forward.
- Accepts write and read request flits, acknowledges each on ack_in, and drives a simple local memory port.
- Returns read data as response flits on rou_out under the same ack protocol.
- Exports a powered flag that the partner's otherside_powered input consumes; the flag drops only after the block has fully drained.

Parameters:
- DWID, 128, data field width
- AWID, 32, address field width
- CWID, 8, command/tag field width
- WID, 2+DWID+AWID+CWID, flit width; layout {kind[1:0], cmd[CWID-1:0], addr[AWID-1:0], data[DWID-1:0]}
- BASE, 0, base address of the accepted window
- WIN_LOG2, 16, window size is 2**WIN_LOG2 bytes
- RQ_DEPTH, 4, maximum outstanding reads plus queued responses
- ACK_TMO, 15, cycles to wait for ack_out before resending a response

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- rou_in  in  WID  request flit; kind 0 = idle, 1 = write, 2 = read, 3 = response
- ack_in  out  3  ack for rou_in: 001 accept, 010 retry, 100 error, 000 none
- rou_out  out  WID  response flit (kind 3) or all-zero
- ack_out  in  3  ack for rou_out, same encoding as ack_in
- pwr_en  in  1  local power request; low = drain and power down
- powered  out  1  this side is live (feeds the partner's otherside_powered)
- mem_req  out  1  memory request strobe, one cycle per request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  AWID  address offset within window (addr - BASE)
- mem_wdata  out  DWID  write data
- mem_ready  in  1  memory can take a request in the next cycle
- mem_rvalid  in  1  read data valid; returns in request order, latency >= 1
- mem_rdata  in  DWID  read data

Behaviour:
- Reset:
  - ack_in, rou_out, mem_req, mem_we, mem_addr, mem_wdata, powered all 0.
  - Queues empty; outstanding count 0; tx FSM in IDLE.
  - Reset mid-operation discards all pending responses without emitting them.
- Request acceptance: a flit with kind != 0 sampled in cycle N gets a registered ack_in in N+1, exactly one cycle wide. Priority:
  - error 100: kind == 3; or address outside [BASE, BASE+2**WIN_LOG2); or pwr_en == 0.
  - retry 010: mem_ready == 0; or (read and outstanding + queue count == RQ_DEPTH).
  - accept 001: otherwise.
- Flit handling:
  - The sender re-presents the flit after a retry. Consecutive flits may arrive back-to-back.
  - Errored flits cause no memory access.
- Memory request: on accept, mem_req = 1 in N+1 together with mem_we, mem_addr and mem_wdata. Drive mem_wdata = 0 for reads.
- Read tracking:
  - On read accept, push {cmd, addr} into a tag FIFO and increment outstanding.
  - On mem_rvalid, pop the tag FIFO, push {tag, addr, rdata} into the response FIFO, and decrement outstanding.
  - mem_rvalid with an empty tag FIFO is a protocol violation; drop it.
  - Simultaneous accept and rvalid in one cycle are handled: the count is unchanged.
- Tx FSM:
  - IDLE: response FIFO non-empty -> SEND.
  - SEND: drive rou_out = {2'd3, tag, addr, data} for one cycle -> WAIT; the timeout counter is cleared.
  - WAIT: rou_out = 0. Next state by ack_out:
    - accept or error: pop -> IDLE. Error is logged only; the response is dropped.
    - retry: -> SEND in the next cycle.
    - no ack for ACK_TMO cycles: -> SEND.
    - multiple ack bits set: treat as error.
  - Minimum response spacing is 2 cycles.
- Power:
  - powered = 1 when pwr_en = 1 (registered, one cycle after pwr_en rises).
  - When pwr_en falls, new requests get error. powered stays 1 until outstanding == 0, both FIFOs are empty and the FSM is in IDLE; it clears in the following cycle.
  - pwr_en rising again during the drain keeps powered = 1.

Decomposition:
- Shared package rou_pkg:
  - kind codes KIND_IDLE/WR/RD/RSP.
  - ack codes ACK_NONE/ACCEPT/RETRY/ERROR.
  - field-offset localparams or functions for kind/cmd/addr/data in terms of DWID, AWID and CWID.
  - the tx FSM state enum.
- One sub-module, rou_sync_fifo (parameterised width and depth, count output), instantiated twice: tag FIFO and response FIFO.

Test Plan:
1. Write kind=1, cmd=8'h5A, addr=BASE+16'h0040, data=128'h1, mem_ready=1 -> ack_in=001 next cycle; mem_req=1, mem_we=1, mem_addr=16'h0040 in the same cycle.
2. Read addr=BASE+8 cmd=8'h11; memory returns rdata=128'hDEAD after 3 cycles; ack_out=001 -> rou_out kind=3, cmd=8'h11, addr=BASE+8, data=128'hDEAD for exactly one cycle, then FIFO empty.
3. Five back-to-back reads with RQ_DEPTH=4 and memory stalled -> first four accepted, fifth gets 010; after one rvalid the re-presented fifth read gets 001.
4. Response with ack_out=010 once, then silence for 15 cycles -> rou_out re-driven after the retry and again after the timeout; ack_out=001 then pops it.
5. Addr=BASE+2**WIN_LOG2, or kind=3 on rou_in -> ack_in=100, mem_req stays 0.
6. Drop pwr_en with 2 reads outstanding -> new requests get 100; powered stays 1 until both responses are acked, then goes 0 one cycle later; async rst mid-read clears everything and rou_out=0.

Source files
------------

// File: rtl/rou_pkg.sv
// Shared definitions for the rou bus target.
//   - Flit kind codes and ack codes used on rou_in/rou_out and ack_in/ack_out.
//   - Field-offset helpers for the flit layout {kind, cmd, addr, data}.
//   - Tx FSM state encoding.
package rou_pkg;

    localparam logic [1:0] KIND_IDLE = 2'd0;
    localparam logic [1:0] KIND_WR   = 2'd1;
    localparam logic [1:0] KIND_RD   = 2'd2;
    localparam logic [1:0] KIND_RSP  = 2'd3;

    localparam logic [2:0] ACK_NONE   = 3'b000;
    localparam logic [2:0] ACK_ACCEPT = 3'b001;
    localparam logic [2:0] ACK_RETRY  = 3'b010;
    localparam logic [2:0] ACK_ERROR  = 3'b100;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SEND,
        TX_WAIT
    } tx_state_t;

    // The data field sits at bit 0; every other field is stacked above it.
    function automatic int addr_lsb(input int dwid);
        return dwid;
    endfunction

    function automatic int cmd_lsb(input int dwid, input int awid);
        return dwid + awid;
    endfunction

    function automatic int kind_lsb(input int dwid, input int awid, input int cwid);
        return dwid + awid + cwid;
    endfunction

    function automatic int flit_width(input int dwid, input int awid, input int cwid);
        return 2 + dwid + awid + cwid;
    endfunction

endpackage

// File: rtl/rou_target_if.sv
// rou bus link between an initiator (master) and a target (slave).
//   rou_in  : request flit, master -> slave
//   ack_in  : ack for rou_in, slave -> master
//   rou_out : response flit, slave -> master
//   ack_out : ack for rou_out, master -> slave
interface rou_target_if #(
    parameter int DWID = 128,
    parameter int AWID = 32,
    parameter int CWID = 8
);
    localparam int WID = 2 + DWID + AWID + CWID;

    logic [WID-1:0] rou_in;
    logic [2:0]     ack_in;
    logic [WID-1:0] rou_out;
    logic [2:0]     ack_out;

    modport master (
        output rou_in,
        output ack_out,
        input  ack_in,
        input  rou_out
    );

    modport slave (
        input  rou_in,
        input  ack_out,
        output ack_in,
        output rou_out
    );

endinterface

// File: rtl/rou_sync_fifo.sv
// Small synchronous show-ahead FIFO.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   pop_data   : current head entry
//   empty      : no entries held
//   count      : number of entries held
module rou_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] store [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push  = push && (count != CW'(DEPTH));
    assign do_pop   = pop && (count != '0);
    assign empty    = (count == '0);
    assign pop_data = store[rd_ptr];

    // Storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rou_target.sv
// Terminal responder on the rou bus.
//   clk, rst    : clock, asynchronous active-high reset
//   rou         : rou link (slave side) carrying rou_in/ack_in/rou_out/ack_out
//   pwr_en      : local power request; low drains and powers down
//   powered     : this side is live, held until fully drained
//   mem_*       : one-request-per-cycle local memory port, in-order read data
// Requests are acked one cycle after they are sampled. Reads park their tag in
// a tag FIFO until data returns, then move to a response FIFO that the tx FSM
// sends out as kind-3 flits and retries until acked.
module rou_target
    import rou_pkg::*;
#(
    parameter int             DWID     = 128,
    parameter int             AWID     = 32,
    parameter int             CWID     = 8,
    parameter int             WID      = flit_width(DWID, AWID, CWID),
    parameter logic [AWID-1:0] BASE    = '0,
    parameter int             WIN_LOG2 = 16,
    parameter int             RQ_DEPTH = 4,
    parameter int             ACK_TMO  = 15
) (
    input  logic            clk,
    input  logic            rst,
    rou_target_if.slave     rou,
    input  logic            pwr_en,
    output logic            powered,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AWID-1:0] mem_addr,
    output logic [DWID-1:0] mem_wdata,
    input  logic            mem_ready,
    input  logic            mem_rvalid,
    input  logic [DWID-1:0] mem_rdata
);

    localparam int ADDR_LSB = addr_lsb(DWID);
    localparam int CMD_LSB  = cmd_lsb(DWID, AWID);
    localparam int KIND_LSB = kind_lsb(DWID, AWID, CWID);
    localparam int CW       = $clog2(RQ_DEPTH + 1);
    localparam int TW       = $clog2(ACK_TMO + 1);

    // One extra bit so a window ending exactly at 2**AWID still compares right.
    localparam logic [AWID:0] WIN_LO = {1'b0, BASE};
    localparam logic [AWID:0] WIN_HI = WIN_LO + ((AWID + 1)'(1) << WIN_LOG2);

    logic [1:0]      req_kind;
    logic [CWID-1:0] req_cmd;
    logic [AWID-1:0] req_addr;
    logic [DWID-1:0] req_data;
    logic            in_win;
    logic            is_wr;
    logic            is_rd;
    logic [CW:0]     occupancy;
    logic [2:0]      ack_nxt;
    logic            accept;

    logic [CWID+AWID-1:0]      tag_head;
    logic                      tag_empty;
    logic [CW-1:0]             tag_count;
    logic                      rd_return;
    logic [CWID+AWID+DWID-1:0] rsp_head;
    logic                      rsp_empty;
    logic [CW-1:0]             rsp_count;

    tx_state_t       state;
    logic [TW-1:0]   tmo_cnt;
    logic [WID-1:0]  rsp_flit;
    logic            ack_done;
    logic            ack_resend;
    logic            rsp_pop;
    logic            drained;

    assign req_kind  = rou.rou_in[KIND_LSB +: 2];
    assign req_cmd   = rou.rou_in[CMD_LSB +: CWID];
    assign req_addr  = rou.rou_in[ADDR_LSB +: AWID];
    assign req_data  = rou.rou_in[0 +: DWID];
    assign is_wr     = (req_kind == KIND_WR);
    assign is_rd     = (req_kind == KIND_RD);
    assign in_win    = ({1'b0, req_addr} >= WIN_LO) && ({1'b0, req_addr} < WIN_HI);
    // Responses still waiting to be sent count against read credit, so reads
    // can never overflow the response FIFO.
    assign occupancy = {1'b0, tag_count} + {1'b0, rsp_count};

    always_comb begin
        ack_nxt = ACK_NONE;
        accept  = 1'b0;
        if (req_kind != KIND_IDLE) begin
            if (req_kind == KIND_RSP || !in_win || !pwr_en) begin
                ack_nxt = ACK_ERROR;
            end else if (!mem_ready || (is_rd && occupancy >= (CW + 1)'(RQ_DEPTH))) begin
                ack_nxt = ACK_RETRY;
            end else begin
                ack_nxt = ACK_ACCEPT;
                accept  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rou.ack_in <= ACK_NONE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            rou.ack_in <= ack_nxt;
            mem_req    <= accept;
            mem_we     <= accept && is_wr;
            mem_addr   <= accept ? (req_addr - BASE) : '0;
            mem_wdata  <= (accept && is_wr) ? req_data : '0;
        end
    end

    // Stray read data with no outstanding tag is dropped here.
    assign rd_return = mem_rvalid && !tag_empty;

    rou_sync_fifo #(
        .WIDTH (CWID + AWID),
        .DEPTH (RQ_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept && is_rd),
        .push_data ({req_cmd, req_addr}),
        .pop       (rd_return),
        .pop_data  (tag_head),
        .empty     (tag_empty),
        .count     (tag_count)
    );

    rou_sync_fifo #(
        .WIDTH (CWID + AWID + DWID),
        .DEPTH (RQ_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_return),
        .push_data ({tag_head, mem_rdata}),
        .pop       (rsp_pop),
        .pop_data  (rsp_head),
        .empty     (rsp_empty),
        .count     (rsp_count)
    );

    assign rsp_flit   = {KIND_RSP, rsp_head};
    // Anything other than a clean retry ends the response: accept, error, or
    // a malformed multi-bit ack (treated as error).
    assign ack_done   = (rou.ack_out != ACK_NONE) && (rou.ack_out != ACK_RETRY);
    assign ack_resend = (rou.ack_out == ACK_RETRY) || (tmo_cnt == TW'(ACK_TMO - 1));
    assign rsp_pop    = (state == TX_WAIT) && ack_done;

    // rou_out is only non-zero during SEND; the head stays in the FIFO until
    // the partner acks, so retries and timeouts simply re-send it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= TX_IDLE;
            rou.rou_out <= '0;
            tmo_cnt     <= '0;
        end else begin
            case (state)
                TX_IDLE: begin
                    if (!rsp_empty) begin
                        state       <= TX_SEND;
                        rou.rou_out <= rsp_flit;
                    end
                end
                TX_SEND: begin
                    state       <= TX_WAIT;
                    rou.rou_out <= '0;
                    tmo_cnt     <= '0;
                end
                TX_WAIT: begin
                    if (ack_done) begin
                        state <= TX_IDLE;
                    end else if (ack_resend) begin
                        state       <= TX_SEND;
                        rou.rou_out <= rsp_flit;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: begin
                    state       <= TX_IDLE;
                    rou.rou_out <= '0;
                end
            endcase
        end
    end

    // Power stays up after pwr_en drops until every read has been answered.
    assign drained = tag_empty && rsp_empty && (state == TX_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            powered <= 1'b0;
        end else begin
            powered <= pwr_en || (powered && !drained);
        end
    end

endmodule

// File: tb/tb_rou_target.sv
// Scoreboard bench for rou_target: stimulus pushes expected acks, memory
// requests and response flits; a negedge monitor pops and compares whenever
// the DUT presents one. A responder acks rou_out using a per-response plan.
module tb_rou_target;
    import rou_pkg::*;

    localparam int              DWID     = 128;
    localparam int              AWID     = 32;
    localparam int              CWID     = 8;
    localparam int              WID      = 2 + DWID + AWID + CWID;
    localparam logic [AWID-1:0] BASE     = '0;
    localparam int              WIN_LOG2 = 16;
    localparam int              RQ_DEPTH = 4;
    localparam int              ACK_TMO  = 15;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            pwr_en = 1'b0;
    logic            powered;
    logic            mem_req;
    logic            mem_we;
    logic [AWID-1:0] mem_addr;
    logic [DWID-1:0] mem_wdata;
    logic            mem_ready = 1'b0;
    logic            mem_rvalid = 1'b0;
    logic [DWID-1:0] mem_rdata = '0;

    int checks = 0;
    int failures = 0;

    logic [2:0]           exp_ack [$];
    logic [AWID+DWID:0]   exp_mem [$];
    logic [WID-1:0]       exp_rsp [$];
    logic [2:0]           ack_plan [$];

    rou_target_if #(.DWID(DWID), .AWID(AWID), .CWID(CWID)) rou ();

    rou_target #(
        .DWID     (DWID),
        .AWID     (AWID),
        .CWID     (CWID),
        .WID      (WID),
        .BASE     (BASE),
        .WIN_LOG2 (WIN_LOG2),
        .RQ_DEPTH (RQ_DEPTH),
        .ACK_TMO  (ACK_TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rou        (rou.slave),
        .pwr_en     (pwr_en),
        .powered    (powered),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one flit for one cycle and queue what the DUT must answer.
    task automatic apply_stimulus(input logic [1:0] kind, input logic [CWID-1:0] cmd,
                                  input logic [AWID-1:0] addr, input logic [DWID-1:0] data,
                                  input logic [2:0] exp);
        rou.rou_in = {kind, cmd, addr, data};
        exp_ack.push_back(exp);
        if (exp == ACK_ACCEPT) begin
            exp_mem.push_back({kind == KIND_WR, addr - BASE, (kind == KIND_WR) ? data : {DWID{1'b0}}});
        end
        tick();
        rou.rou_in = '0;
    endtask

    task automatic mem_return(input logic [DWID-1:0] data, input logic [CWID-1:0] cmd,
                              input logic [AWID-1:0] addr, input int copies);
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        for (int i = 0; i < copies; i++) begin
            exp_rsp.push_back({KIND_RSP, cmd, addr, data});
        end
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
    endtask

    task automatic wait_rsp_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_rsp.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (exp_rsp.size() != 0) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d_pending required=0_pending", name, exp_rsp.size());
        end
    endtask

    // Monitor: every DUT output event consumes one scoreboard entry.
    always @(negedge clk) begin
        logic [2:0]         a;
        logic [AWID+DWID:0] m;
        logic [WID-1:0]     r;
        if (!rst) begin
            if (rou.ack_in != ACK_NONE) begin
                if (exp_ack.size() == 0) begin
                    check_output("ack_in_unexpected", 256'(rou.ack_in), '0);
                end else begin
                    a = exp_ack.pop_front();
                    check_output("ack_in", 256'(rou.ack_in), 256'(a));
                end
            end
            if (mem_req) begin
                if (exp_mem.size() == 0) begin
                    check_output("mem_req_unexpected", 256'({mem_we, mem_addr, mem_wdata}), '0);
                end else begin
                    m = exp_mem.pop_front();
                    check_output("mem_req", 256'({mem_we, mem_addr, mem_wdata}), 256'(m));
                end
            end
            if (rou.rou_out != '0) begin
                if (exp_rsp.size() == 0) begin
                    check_output("rou_out_unexpected", 256'(rou.rou_out), '0);
                end else begin
                    r = exp_rsp.pop_front();
                    check_output("rou_out", 256'(rou.rou_out), 256'(r));
                end
            end
        end
    end

    // Responder: acks each presented response one cycle later, per plan.
    initial begin
        logic [2:0] plan;
        rou.ack_out = ACK_NONE;
        forever begin
            @(negedge clk);
            if (!rst && rou.rou_out != '0) begin
                plan = (ack_plan.size() != 0) ? ack_plan.pop_front() : ACK_ACCEPT;
                @(posedge clk);
                #1;
                rou.ack_out = plan;
                @(posedge clk);
                #1;
                rou.ack_out = ACK_NONE;
            end
        end
    end

    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        rou.rou_in = '0;
        tick();
        tick();
        check_output("rst_ack_in", 256'(rou.ack_in), '0);
        check_output("rst_rou_out", 256'(rou.rou_out), '0);
        check_output("rst_mem", 256'({mem_req, mem_we, mem_addr, mem_wdata}), '0);
        check_output("rst_powered", 256'(powered), '0);

        rst       = 1'b0;
        pwr_en    = 1'b1;
        mem_ready = 1'b1;
        check_output("powered_before_edge", 256'(powered), '0);
        tick();
        check_output("powered_rise", 256'(powered), 256'(1));

        // Write accept
        apply_stimulus(KIND_WR, 8'h5A, BASE + 32'h40, 128'h1, ACK_ACCEPT);
        tick();

        // Single read, data after 3 cycles
        apply_stimulus(KIND_RD, 8'h11, BASE + 32'h8, '0, ACK_ACCEPT);
        tick();
        tick();
        mem_return(128'hDEAD, 8'h11, BASE + 32'h8, 1);
        wait_rsp_drain("rsp_single", 30);
        repeat (4) tick();

        // Five back-to-back reads against a four-entry budget
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(KIND_RD, 8'h21 + 8'(i), BASE + 32'h100 + 32'(i * 16), '0,
                           (i < 4) ? ACK_ACCEPT : ACK_RETRY);
        end
        tick();
        mem_return(128'hA1, 8'h21, BASE + 32'h100, 1);
        wait_rsp_drain("rsp_credit", 30);
        tick();
        tick();
        apply_stimulus(KIND_RD, 8'h25, BASE + 32'h140, '0, ACK_ACCEPT);
        tick();
        for (int i = 1; i < 5; i++) begin
            mem_return(128'hA1 + 128'(i), 8'h21 + 8'(i), BASE + 32'h100 + 32'(i * 16), 1);
        end
        wait_rsp_drain("rsp_credit_rest", 60);
        repeat (4) tick();

        // Retry once, then time out, then accept
        ack_plan.push_back(ACK_RETRY);
        ack_plan.push_back(ACK_NONE);
        ack_plan.push_back(ACK_ACCEPT);
        apply_stimulus(KIND_RD, 8'h44, BASE + 32'h200, '0, ACK_ACCEPT);
        tick();
        mem_return(128'hBEEF, 8'h44, BASE + 32'h200, 3);
        wait_rsp_drain("rsp_retry_tmo", 80);
        repeat (4) tick();

        // Multi-bit ack acts as error: dropped, never re-sent
        ack_plan.push_back(3'b011);
        apply_stimulus(KIND_RD, 8'h55, BASE + 32'h300, '0, ACK_ACCEPT);
        tick();
        mem_return(128'hC0FFEE, 8'h55, BASE + 32'h300, 1);
        wait_rsp_drain("rsp_multibit", 30);
        repeat (ACK_TMO + 6) tick();

        // Window edges, bad kind, memory back-pressure
        apply_stimulus(KIND_WR, 8'h01, BASE + 32'hFFFF, 128'h77, ACK_ACCEPT);
        apply_stimulus(KIND_WR, 8'h02, BASE + 32'h10000, 128'h88, ACK_ERROR);
        apply_stimulus(KIND_RSP, 8'h03, BASE + 32'h10, 128'h99, ACK_ERROR);
        mem_ready = 1'b0;
        apply_stimulus(KIND_WR, 8'h04, BASE + 32'h80, 128'h5, ACK_RETRY);
        mem_ready = 1'b1;
        apply_stimulus(KIND_WR, 8'h04, BASE + 32'h80, 128'h5, ACK_ACCEPT);
        repeat (3) tick();

        // Power down with two reads outstanding
        apply_stimulus(KIND_RD, 8'h61, BASE + 32'h400, '0, ACK_ACCEPT);
        apply_stimulus(KIND_RD, 8'h62, BASE + 32'h410, '0, ACK_ACCEPT);
        pwr_en = 1'b0;
        apply_stimulus(KIND_WR, 8'h63, BASE + 32'h420, 128'h3, ACK_ERROR);
        apply_stimulus(KIND_RD, 8'h64, BASE + 32'h430, '0, ACK_ERROR);
        tick();
        check_output("powered_hold_outstanding", 256'(powered), 256'(1));
        mem_return(128'hB1, 8'h61, BASE + 32'h400, 1);
        mem_return(128'hB2, 8'h62, BASE + 32'h410, 1);
        begin
            int n;
            n = 0;
            while (!(rou.rou_out != '0 && rou.rou_out[DWID-1:0] == 128'hB2) && n < 40) begin
                tick();
                n++;
            end
            check_output("last_rsp_seen", 256'(n < 40), 256'(1));
        end
        check_output("powered_during_send", 256'(powered), 256'(1));
        tick();
        check_output("powered_during_wait", 256'(powered), 256'(1));
        tick();
        check_output("powered_after_pop", 256'(powered), 256'(1));
        tick();
        check_output("powered_dropped", 256'(powered), '0);

        // Reset in the middle of a read: response is discarded
        pwr_en = 1'b1;
        tick();
        tick();
        check_output("powered_back", 256'(powered), 256'(1));
        apply_stimulus(KIND_RD, 8'h77, BASE + 32'h500, '0, ACK_ACCEPT);
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 128'hE1;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        #2;
        rst = 1'b1;
        #1;
        check_output("arst_rou_out", 256'(rou.rou_out), '0);
        check_output("arst_ack_mem", 256'({rou.ack_in, mem_req, mem_addr}), '0);
        check_output("arst_powered", 256'(powered), '0);
        tick();
        tick();
        rst = 1'b0;
        repeat (ACK_TMO + 10) tick();
        check_output("powered_after_rst", 256'(powered), 256'(1));

        check_output("ack_queue_left", 256'(exp_ack.size()), '0);
        check_output("mem_queue_left", 256'(exp_mem.size()), '0);
        check_output("rsp_queue_left", 256'(exp_rsp.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
